button_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 26 ++
 rtl/btn_debounce_ch.sv | 173 +++++++++++++++++
 rtl/button_conditioner.sv | 45 ++++
 tb/tb_button_conditioner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// btn_pkg : shared state encoding and button index constants
// Rev 1.0 : initial release
// ============================================================================
package btn_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;

  typedef enum logic [1:0] {
    S_IDLE         = ST_IDLE,
    S_PRESS_WAIT   = ST_PRESS_WAIT,
    S_HELD         = ST_HELD,
    S_RELEASE_WAIT = ST_RELEASE_WAIT
  } btn_state_e;

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// btn_debounce_ch : one button channel - sync, debounce FSM, press/release pulses
// Optional auto-repeat when BTN_REPEAT_EN is defined.   Rev 1.0 : initial release
// ============================================================================
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  btn_state_e         r_state;
  btn_state_e         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_press_evt;
  logic               w_release_evt;
  logic               r_press_evt;
  logic               r_release_evt;
  logic               w_rpt_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_evt   = 1'b0;
    w_release_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_sync2) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
          w_press_evt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!r_sync2) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_release_evt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam int                 c_rpt_max   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int                 c_rpt_w     = $clog2(c_rpt_max + 1);
  localparam logic [c_rpt_w-1:0] c_dly_last  = c_rpt_w'(REPEAT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_rate_last = c_rpt_w'(REPEAT_RATE - 1);

  logic [c_rpt_w-1:0] r_rpt_cnt;
  logic               r_rpt_phase;
  logic               w_rpt_evt;
  logic               r_rpt_evt;

  // r_rpt_phase selects the initial delay (0) or the steady repeat period (1)
  assign w_rpt_evt = (r_state == S_HELD) && r_sync2 &&
                     (r_rpt_cnt == (r_rpt_phase ? c_rate_last : c_dly_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
      r_rpt_evt   <= 1'b0;
    end else begin
      r_rpt_evt <= w_rpt_evt;
      if (r_state == S_HELD) begin
        if (r_sync2) begin
          if (w_rpt_evt) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b1;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
          end
        end
      end else if (r_state == S_RELEASE_WAIT) begin
        if (r_sync2) begin
          r_rpt_cnt   <= '0;
          r_rpt_phase <= 1'b0;
        end
      end else begin
        r_rpt_cnt   <= '0;
        r_rpt_phase <= 1'b0;
      end
    end
  end

  assign w_rpt_press = r_rpt_evt;
`else
  assign w_rpt_press = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_press_evt   <= 1'b0;
      r_release_evt <= 1'b0;
      o_level       <= 1'b0;
      o_press       <= 1'b0;
      o_release     <= 1'b0;
    end else begin
      r_press_evt   <= w_press_evt;
      r_release_evt <= w_release_evt;
      o_level       <= (r_state == S_HELD) || (r_state == S_RELEASE_WAIT);
      o_press       <= r_press_evt | w_rpt_press;
      o_release     <= r_release_evt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// button_conditioner : NUM_BTN independent debounced push-button channels
// Optional auto-repeat when BTN_REPEAT_EN is defined.   Rev 1.0 : initial release
// ============================================================================
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
`endif
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (btn_raw[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g])
    );
  end

  assign any_press = |btn_press;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// Bench for button_conditioner: run-length debounce model checked every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_press;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB)
`ifdef BTN_REPEAT_EN
    ,
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a channel's level flips once DB+1 consecutive synchronized samples
  // disagree with it; outputs appear one edge after the flip.
  logic [NB-1:0] m_q1, m_q2;
  bit            m_lvl [NB];
  int            m_run [NB];
  int            m_age [NB];
  bit            m_pp  [NB];
  bit            m_pr  [NB];
  bit            m_s;
  bit            m_valid = 1'b0;
  logic [NB-1:0] e_level, e_press, e_release;

  function automatic bit rpt_fire(input int age);
`ifdef BTN_REPEAT_EN
    return (age == RD) || ((age > RD) && (((age - RD) % RR) == 0));
`else
    return (age < 0);
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_q1 = '0; m_q2 = '0;
      e_level = '0; e_press = '0; e_release = '0;
      for (int c = 0; c < NB; c++) begin
        m_lvl[c] = 0; m_run[c] = 0; m_age[c] = 0; m_pp[c] = 0; m_pr[c] = 0;
      end
    end else begin
      for (int c = 0; c < NB; c++) begin
        e_level[c]   = m_lvl[c];
        e_press[c]   = m_pp[c];
        e_release[c] = m_pr[c];
        m_pp[c] = 0;
        m_pr[c] = 0;
        m_s = m_q2[c];
        if (m_s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_lvl[c] = !m_lvl[c];
            m_run[c] = 0;
            m_age[c] = 0;
            if (m_lvl[c]) m_pp[c] = 1;
            else          m_pr[c] = 1;
          end
        end else begin
          if (m_lvl[c] && m_run[c] == 0) begin
            m_age[c]++;
            if (rpt_fire(m_age[c])) m_pp[c] = 1;
          end else begin
            m_age[c] = 0;
          end
          m_run[c] = 0;
        end
      end
      m_q2 = m_q1;
      m_q1 = btn_raw;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_level",   btn_level,   e_level);
      check("model_press",   btn_press,   e_press);
      check("model_release", btn_release, e_release);
      check("model_any",     any_press,   (e_press != '0));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit exp_rpt;
    rst     = 1'b1;
    btn_raw = '0;
    wait_n(2);
    check("reset_level",   btn_level,   0);
    check("reset_press",   btn_press,   0);
    check("reset_release", btn_release, 0);
    check("reset_any",     any_press,   0);
    rst = 1'b0;
    wait_n(3);

    // clean press on left
    btn_raw[BTN_LEFT] = 1'b1;
    wait_n(7);
    check("clean_c6_press", btn_press, 0);
    check("clean_c6_level", btn_level, 0);
    wait_n(1);
    check("clean_c7_press", btn_press, 4'b0001);
    check("clean_c7_level", btn_level, 4'b0001);
    check("clean_c7_any",   any_press, 1);
    wait_n(1);
    check("clean_c8_press", btn_press, 0);
    wait_n(2);

    // release with a 2-cycle glitch back high, then a clean release
    btn_raw[BTN_LEFT] = 1'b0;
    wait_n(2);
    btn_raw[BTN_LEFT] = 1'b1;
    wait_n(2);
    btn_raw[BTN_LEFT] = 1'b0;
    wait_n(7);
    check("release_t6_level", btn_level, 4'b0001);
    check("release_t6_rel",   btn_release, 0);
    wait_n(1);
    check("release_t7_rel",   btn_release, 4'b0001);
    check("release_t7_level", btn_level, 0);
    wait_n(1);
    check("release_t8_rel",   btn_release, 0);
    wait_n(3);

    // bouncy press on right: high 3, low 1, high steady
    btn_raw[BTN_RIGHT] = 1'b1;
    wait_n(3);
    btn_raw[BTN_RIGHT] = 1'b0;
    wait_n(1);
    btn_raw[BTN_RIGHT] = 1'b1;
    wait_n(7);
    check("bounce_f6_press", btn_press, 0);
    wait_n(1);
    check("bounce_f7_press", btn_press, 4'b0010);
    wait_n(3);
    btn_raw[BTN_RIGHT] = 1'b0;
    wait_n(12);

    // simultaneous press on all channels
    btn_raw = 4'b1111;
    wait_n(7);
    check("simul_c6_press", btn_press, 0);
    wait_n(1);
    check("simul_c7_press", btn_press, 4'b1111);
    check("simul_c7_any",   any_press, 1);
    wait_n(1);
    check("simul_c8_press", btn_press, 0);
    check("simul_c8_any",   any_press, 0);
    wait_n(5);

    // reset while held; up stays pressed and must re-debounce
    rst     = 1'b1;
    btn_raw = 4'b0100;
    wait_n(1);
    check("midrst_level",   btn_level,   0);
    check("midrst_press",   btn_press,   0);
    check("midrst_release", btn_release, 0);
    rst = 1'b0;
    wait_n(7);
    check("midrst_r7_press", btn_press, 0);
    wait_n(1);
    check("midrst_r8_press", btn_press[BTN_UP], 1);
    wait_n(3);
    btn_raw = '0;
    wait_n(12);

    // long hold on down: auto-repeat schedule (single pulse without repeat)
    btn_raw[BTN_DOWN] = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
`ifdef BTN_REPEAT_EN
      exp_rpt = (c == 7) || (c == 27) || (c == 35) || (c == 43) || (c == 51) || (c == 59);
`else
      exp_rpt = (c == 7);
`endif
      check($sformatf("hold_press_c%0d", c), btn_press[BTN_DOWN], exp_rpt);
      if (c == 59) btn_raw[BTN_DOWN] = 1'b0;
    end
    wait_n(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
